// File: rtl/gpio_pkg.sv
// Shared types and register offsets for the GPIO MMIO slave.
package gpio_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    localparam logic [7:0] OFF_OUT = 8'h00;
    localparam logic [7:0] OFF_SET = 8'h04;
    localparam logic [7:0] OFF_CLR = 8'h08;
    localparam logic [7:0] OFF_IN  = 8'h0C;
    localparam logic [7:0] OFF_EN  = 8'h10;
    localparam logic [7:0] OFF_STS = 8'h14;
    localparam logic [7:0] OFF_DEB = 8'h18;

endpackage

// File: rtl/gpio_debounce.sv
// One input bit: 2-flop synchroniser, debounce counter, rising-edge pulse.
module gpio_debounce #(
    parameter int DEB_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             pin,
    input  logic [DEB_W-1:0] deb_cycles,
    output logic             level,
    output logic             rise
);

    logic             s1;
    logic             s2;
    logic [DEB_W-1:0] cnt;
    logic [DEB_W-1:0] cnt_nxt;
    logic [DEB_W:0]   inc;
    logic             lvl_nxt;

    // >= lets a lowered threshold take effect at once; count never wraps
    always_comb begin
        inc     = {1'b0, cnt} + {{DEB_W{1'b0}}, 1'b1};
        lvl_nxt = level;
        cnt_nxt = '0;
        if (deb_cycles == '0) begin
            lvl_nxt = s2;
        end else if (s2 != level) begin
            if (inc >= {1'b0, deb_cycles}) begin
                lvl_nxt = s2;
            end else begin
                cnt_nxt = inc[DEB_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            cnt   <= cnt_nxt;
            level <= lvl_nxt;
            rise  <= lvl_nxt & ~level;
        end
    end

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO slave: slot-bus FSM, register file, debounced inputs and irq.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_IN  = 9,
    parameter int NUM_OUT = 4,
    parameter int DEB_W   = 16,
    parameter int DEB_RST = 1000
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               chip_select,
    input  logic               read,
    input  logic               write,
    input  logic               transaction_completed,
    input  logic [7:0]         addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               wr_done,
    output logic               rd_done,
    output logic               idle,
    output logic               slave_error,
    output logic               decode_error,
    output logic               irq,
    input  logic [NUM_IN-1:0]  in_ports,
    output logic [NUM_OUT-1:0] out_ports
);

    state_t             state;
    logic [7:0]         a_q;
    logic [31:0]        d_q;
    logic               w_q;
    logic [NUM_IN-1:0]  en_q;
    logic [NUM_IN-1:0]  sts_q;
    logic [NUM_IN-1:0]  lvl;
    logic [NUM_IN-1:0]  rise;
    logic [NUM_IN-1:0]  w1c;
    logic [DEB_W-1:0]   deb_q;
    logic [31:0]        rdata;
    logic               serr;
    logic               derr;
    logic               ok;
    logic               unused_ok;

    assign unused_ok = ^d_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        gpio_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk        (clk),
            .arst_n     (arst_n),
            .pin        (in_ports[i]),
            .deb_cycles (deb_q),
            .level      (lvl[i]),
            .rise       (rise[i])
        );
    end

    always_comb begin
        rdata = '0;
        serr  = 1'b0;
        derr  = 1'b0;
        unique case (a_q)
            OFF_OUT:          rdata = 32'(out_ports);
            OFF_SET, OFF_CLR: serr  = !w_q;
            OFF_IN: begin
                serr  = w_q;
                rdata = 32'(lvl);
            end
            OFF_EN:           rdata = 32'(en_q);
            OFF_STS:          rdata = 32'(sts_q);
            OFF_DEB:          rdata = 32'(deb_q);
            default:          derr  = 1'b1;
        endcase
        ok = !serr && !derr;
    end

    assign w1c = (state == S_ACTIVE && w_q && a_q == OFF_STS)
               ? d_q[NUM_IN-1:0] : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= S_IDLE;
            idle         <= 1'b1;
            a_q          <= '0;
            d_q          <= '0;
            w_q          <= 1'b0;
            rd_data      <= '0;
            wr_done      <= 1'b0;
            rd_done      <= 1'b0;
            slave_error  <= 1'b0;
            decode_error <= 1'b0;
            out_ports    <= '0;
            en_q         <= '0;
            deb_q        <= DEB_W'(DEB_RST);
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (chip_select && (read || write)) begin
                        state <= S_ACTIVE;
                        idle  <= 1'b0;
                        a_q   <= addr;
                        d_q   <= wr_data;
                        w_q   <= write;
                    end
                end
                S_ACTIVE: begin
                    state        <= S_DONE;
                    wr_done      <= w_q && ok;
                    rd_done      <= !w_q && ok;
                    slave_error  <= serr;
                    decode_error <= derr;
                    rd_data      <= (!w_q && ok) ? rdata : '0;
                    if (w_q && ok) begin
                        unique case (a_q)
                            OFF_OUT: out_ports <= d_q[NUM_OUT-1:0];
                            OFF_SET: out_ports <= out_ports | d_q[NUM_OUT-1:0];
                            OFF_CLR: out_ports <= out_ports & ~d_q[NUM_OUT-1:0];
                            OFF_EN:  en_q      <= d_q[NUM_IN-1:0];
                            OFF_DEB: deb_q     <= d_q[DEB_W-1:0];
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    if (transaction_completed) begin
                        state        <= S_IDLE;
                        idle         <= 1'b1;
                        rd_data      <= '0;
                        wr_done      <= 1'b0;
                        rd_done      <= 1'b0;
                        slave_error  <= 1'b0;
                        decode_error <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

    // a new edge beats a same-cycle W1C of that bit
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sts_q <= '0;
            irq   <= 1'b0;
        end else begin
            sts_q <= (sts_q & ~w1c) | rise;
            irq   <= |(sts_q & en_q);
        end
    end

endmodule
